srm_controller: RTL and testbench



---
 rtl/srm_controller_if.sv | 49 ++++
 rtl/srm_controller.sv | 217 +++++++++++++++++++++
 tb/tb_srm_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/srm_controller_if.sv
// -----------------------------------------------------------------------------
// srm_controller_if
// Bundle between the Simple RISC Machine controller and the rest of the CPU.
//
// Instruction side : in (16-bit instruction word), load (capture into IR),
//                    s (start), w (idle), bad_instr (undefined-instruction pulse)
// Datapath side    : datapath_in (extended imm8), vsel, write, loada, loadb,
//                    asel, bsel, loadc, loads, writenum, readnum, shift, ALUop
//
// master : the controller (receives instruction/start, drives datapath controls)
// slave  : the surrounding CPU/datapath (supplies instruction/start, consumes
//          datapath controls)
// -----------------------------------------------------------------------------
interface srm_controller_if #(
    parameter int DW = 16
);
    logic [15:0]   in;
    logic          load;
    logic          s;
    logic          w;
    logic          bad_instr;
    logic [DW-1:0] datapath_in;
    logic          vsel;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          asel;
    logic          bsel;
    logic          loadc;
    logic          loads;
    logic [2:0]    writenum;
    logic [2:0]    readnum;
    logic [1:0]    shift;
    logic [1:0]    ALUop;

    modport master (
        input  in, load, s,
        output w, bad_instr, datapath_in,
        output vsel, write, loada, loadb, asel, bsel, loadc, loads,
        output writenum, readnum, shift, ALUop
    );

    modport slave (
        output in, load, s,
        input  w, bad_instr, datapath_in,
        input  vsel, write, loada, loadb, asel, bsel, loadc, loads,
        input  writenum, readnum, shift, ALUop
    );
endinterface

// File: rtl/srm_controller.sv
// -----------------------------------------------------------------------------
// srm_controller
// Instruction register, decoder and multi-cycle control FSM for the Simple
// RISC Machine. Executes one instruction (MOV imm, MOV reg, ADD, CMP, AND, MVN)
// per start pulse and drives every datapath control input.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          srm_controller_if.master (instruction in/load/s, w, bad_instr,
//                datapath_in and all datapath control strobes/selects)
//   instr_count  [15:0] completed-instruction counter (only with
//                SRM_INSTR_CNT_EN defined)
//
// Parameters:
//   DW        width of datapath_in (>= 8)
//   SIGN_EXT  1 = sign-extend imm8, 0 = zero-extend
//
// Optional feature macro: SRM_INSTR_CNT_EN
// -----------------------------------------------------------------------------
module srm_controller #(
    parameter int DW       = 16,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    srm_controller_if.master    bus
`ifdef SRM_INSTR_CNT_EN
    ,
    output logic [15:0]         instr_count
`endif
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_WRITE_IMM = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_ALU       = 3'd4,
        S_WRITE_REG = 3'd5
    } state_t;

    typedef struct packed {
        logic       vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctrl_t;

    // First state entered from WAIT for a given instruction; WAIT means the
    // opcode/op pair is undefined.
    function automatic state_t first_state(input logic [15:0] ins);
        state_t st;
        case ({ins[15:13], ins[12:11]})
            5'b110_10:                     st = S_WRITE_IMM;
            5'b110_00:                     st = S_GET_B;
            5'b101_00, 5'b101_01, 5'b101_10: st = S_GET_A;
            5'b101_11:                     st = S_GET_B;
            default:                       st = S_WAIT;
        endcase
        return st;
    endfunction

    function automatic logic is_cmp(input logic [15:0] ins);
        return (ins[15:13] == 3'b101) && (ins[12:11] == 2'b01);
    endfunction

    // Moore output decode of a state for the instruction in flight.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ins);
        ctrl_t c;
        logic  mov_reg;
        c       = '0;
        mov_reg = (ins[15:13] == 3'b110);
        case (st)
            S_WRITE_IMM: begin
                c.vsel     = 1'b1;
                c.write    = 1'b1;
                c.writenum = ins[10:8];
            end
            S_GET_A: begin
                c.readnum = ins[10:8];
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = ins[2:0];
                c.loadb   = 1'b1;
            end
            S_ALU: begin
                c.shift = ins[4:3];
                // MOV-reg reuses the adder with A forced to zero.
                c.aluop = mov_reg ? 2'b00 : ins[12:11];
                c.asel  = mov_reg;
                c.loadc = ~is_cmp(ins);
                c.loads = is_cmp(ins);
            end
            S_WRITE_REG: begin
                c.write    = 1'b1;
                c.writenum = ins[7:5];
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      r_state;
    logic [15:0] r_ir;
    // Copy of the instruction being executed. IR may be reloaded on the very
    // edge that starts an instruction, so the sequence runs from this copy.
    logic [15:0] r_exec;
    ctrl_t       r_ctrl;
    logic        r_w;
    logic        r_bad;

    state_t      w_next_state;
    state_t      w_first;
    logic [15:0] w_next_exec;
    logic        w_bad_next;
    logic        w_done;
    logic [15:0] w_imm_src;
    logic [7:0]  w_imm8;

    always_comb begin
        w_next_state = r_state;
        w_next_exec  = r_exec;
        w_bad_next   = 1'b0;
        w_first      = first_state(r_ir);
        case (r_state)
            S_WAIT: begin
                if (bus.s) begin
                    w_next_exec  = r_ir;
                    w_next_state = w_first;
                    w_bad_next   = (w_first == S_WAIT);
                end
            end
            S_WRITE_IMM: w_next_state = S_WAIT;
            S_GET_A:     w_next_state = S_GET_B;
            S_GET_B:     w_next_state = S_ALU;
            S_ALU:       w_next_state = is_cmp(r_exec) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: w_next_state = S_WAIT;
            default:     w_next_state = S_WAIT;
        endcase
    end

    // A legal instruction completes on any return to WAIT from a busy state.
    assign w_done = (r_state != S_WAIT) && (w_next_state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
            r_exec  <= '0;
            r_ctrl  <= '0;
            r_w     <= 1'b1;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_exec  <= w_next_exec;
            if (bus.load && (r_state == S_WAIT))
                r_ir <= bus.in;
            // Outputs are registered by decoding the state being entered.
            r_ctrl  <= ctrl_for(w_next_state, w_next_exec);
            r_w     <= (w_next_state == S_WAIT);
            r_bad   <= w_bad_next;
        end
    end

`ifdef SRM_INSTR_CNT_EN
    logic [15:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (w_done)
            r_count <= r_count + 16'd1;
    end
    assign instr_count = r_count;
`else
    logic w_done_unused;
    assign w_done_unused = w_done;
`endif

    // While idle the immediate follows IR; while busy it follows the
    // instruction in flight so a same-edge reload cannot corrupt WRITE_IMM.
    assign w_imm_src = (r_state == S_WAIT) ? r_ir : r_exec;
    assign w_imm8    = w_imm_src[7:0];

    generate
        if (SIGN_EXT) begin : g_sext
            assign bus.datapath_in = {{(DW-8){w_imm8[7]}}, w_imm8};
        end else begin : g_zext
            assign bus.datapath_in = {{(DW-8){1'b0}}, w_imm8};
        end
    endgenerate

    assign bus.w         = r_w;
    assign bus.bad_instr = r_bad;
    assign bus.vsel      = r_ctrl.vsel;
    assign bus.write     = r_ctrl.write;
    assign bus.loada     = r_ctrl.loada;
    assign bus.loadb     = r_ctrl.loadb;
    assign bus.asel      = r_ctrl.asel;
    assign bus.bsel      = r_ctrl.bsel;
    assign bus.loadc     = r_ctrl.loadc;
    assign bus.loads     = r_ctrl.loads;
    assign bus.writenum  = r_ctrl.writenum;
    assign bus.readnum   = r_ctrl.readnum;
    assign bus.shift     = r_ctrl.shift;
    assign bus.ALUop     = r_ctrl.aluop;

endmodule

// File: tb/tb_srm_controller.sv
module tb_srm_controller;

    localparam int DW = 16;

    logic clk;
    logic rst_n;
    srm_controller_if #(.DW(DW)) bus ();
`ifdef SRM_INSTR_CNT_EN
    logic [15:0] instr_count;
`endif

    srm_controller #(.DW(DW), .SIGN_EXT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SRM_INSTR_CNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    // Packed control word: {vsel,write,loada,loadb,asel,bsel,loadc,loads,
    //                       writenum,readnum,shift,ALUop} = 18 bits
    typedef logic [17:0] cw_t;
    typedef cw_t [4:0] cw_arr_t;

    typedef struct {
        string       name;
        logic [15:0] instr;
        int          ncyc;
        cw_arr_t     exp;
        logic [15:0] exp_dp;
    } vec_t;

    function automatic cw_t mk(input logic vs, input logic wr, input logic la,
                               input logic lb, input logic as, input logic lc,
                               input logic ls, input logic [2:0] wn,
                               input logic [2:0] rn, input logic [1:0] sh,
                               input logic [1:0] op);
        return {vs, wr, la, lb, as, 1'b0, lc, ls, wn, rn, sh, op};
    endfunction

    function automatic cw_t get_cw();
        return {bus.vsel, bus.write, bus.loada, bus.loadb, bus.asel, bus.bsel,
                bus.loadc, bus.loads, bus.writenum, bus.readnum, bus.shift, bus.ALUop};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_ir(input logic [15:0] word);
        bus.in   = word;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    // Pulse s from WAIT and compare each cycle until w returns. With noise=1,
    // load/s are held high while busy and must have no effect.
    task automatic run_seq(input string name, input int ncyc, input cw_arr_t exp,
                           input logic [15:0] exp_dp, input logic noise);
        bus.s = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            step();
            if (k == 1 && !noise) bus.s = 1'b0;
            if (k < ncyc) begin
                chk($sformatf("%s c%0d ctrl", name, k), 32'(get_cw()), 32'(exp[k-1]));
                chk($sformatf("%s c%0d w", name, k), 32'(bus.w), 32'd0);
                chk($sformatf("%s c%0d bad", name, k), 32'(bus.bad_instr), 32'd0);
                if (k == 1)
                    chk($sformatf("%s dp_in", name), 32'(bus.datapath_in), 32'(exp_dp));
                if (noise && k == 1) begin
                    bus.in   = 16'hD3AA;
                    bus.load = 1'b1;
                end
                if (noise && k == ncyc - 1) begin
                    bus.s    = 1'b0;
                    bus.load = 1'b0;
                end
            end else begin
                chk($sformatf("%s done w", name), 32'(bus.w), 32'd1);
                chk($sformatf("%s done ctrl", name), 32'(get_cw()), 32'd0);
            end
        end
        exp_cnt++;
        $display("instr %s: %0d cycles to idle, controls=%h", name, ncyc, get_cw());
    endtask

    vec_t vecs[9];

    initial begin
        cw_arr_t e;
        bus.in   = '0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        rst_n    = 1'b0;

        // Table: MOV imm, ADD, CMP, MVN, MOV reg, AND
        e = '0; e[0] = mk(1,1,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00);
        vecs[0] = '{"MOV R0,#7", 16'hD007, 2, e, 16'h0007};
        e = '0; e[0] = mk(1,1,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00);
        vecs[1] = '{"MOV R1,#-7", 16'hD1F9, 2, e, 16'hFFF9};
        e = '0; e[0] = mk(1,1,0,0,0,0,0,3'd1,3'd0,2'b00,2'b00);
        vecs[2] = '{"MOV R1,#2", 16'hD102, 2, e, 16'h0002};
        e = '0;
        e[0] = mk(0,0,1,0,0,0,0,3'd0,3'd1,2'b00,2'b00);
        e[1] = mk(0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b00);
        e[2] = mk(0,0,0,0,0,1,0,3'd0,3'd0,2'b01,2'b00);
        e[3] = mk(0,1,0,0,0,0,0,3'd2,3'd0,2'b00,2'b00);
        vecs[3] = '{"ADD R2,R1,R0,LSL#1", 16'hA148, 5, e, 16'h0048};
        e = '0;
        e[0] = mk(0,0,1,0,0,0,0,3'd0,3'd0,2'b00,2'b00);
        e[1] = mk(0,0,0,1,0,0,0,3'd0,3'd1,2'b00,2'b00);
        e[2] = mk(0,0,0,0,0,0,1,3'd0,3'd0,2'b00,2'b01);
        vecs[4] = '{"CMP R0,R1", 16'hA801, 4, e, 16'h0001};
        e = '0;
        e[0] = mk(0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b00);
        e[1] = mk(0,0,0,0,0,1,0,3'd0,3'd0,2'b00,2'b11);
        e[2] = mk(0,1,0,0,0,0,0,3'd3,3'd0,2'b00,2'b00);
        vecs[5] = '{"MVN R3,R0", 16'hB860, 4, e, 16'h0060};
        e = '0;
        e[0] = mk(0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b00);
        e[1] = mk(0,0,0,0,1,1,0,3'd0,3'd0,2'b00,2'b00);
        e[2] = mk(0,1,0,0,0,0,0,3'd4,3'd0,2'b00,2'b00);
        vecs[6] = '{"MOV R4,R0", 16'hC080, 4, e, 16'hFF80};
        e = '0;
        e[0] = mk(0,0,1,0,0,0,0,3'd0,3'd2,2'b00,2'b00);
        e[1] = mk(0,0,0,1,0,0,0,3'd0,3'd0,2'b00,2'b00);
        e[2] = mk(0,0,0,0,0,1,0,3'd0,3'd0,2'b11,2'b10);
        e[3] = mk(0,1,0,0,0,0,0,3'd5,3'd0,2'b00,2'b00);
        vecs[7] = '{"AND R5,R2,R0,ASR", 16'hB2B8, 5, e, 16'hFFB8};
        e = '0;
        e[0] = mk(0,0,0,1,0,0,0,3'd0,3'd3,2'b00,2'b00);
        e[1] = mk(0,0,0,0,1,1,0,3'd0,3'd0,2'b10,2'b00);
        e[2] = mk(0,1,0,0,0,0,0,3'd7,3'd0,2'b00,2'b00);
        vecs[8] = '{"MOV R7,R3,LSR", 16'hC0F3, 4, e, 16'hFFF3};

        // Reset state
        step();
        chk("reset w", 32'(bus.w), 32'd1);
        chk("reset ctrl", 32'(get_cw()), 32'd0);
        chk("reset bad", 32'(bus.bad_instr), 32'd0);
        chk("reset dp_in", 32'(bus.datapath_in), 32'd0);
        rst_n = 1'b1;
        step();

        // Abort mid-GET_B with an asynchronous reset
        load_ir(16'hA148);
        bus.s = 1'b1;
        step();
        bus.s = 1'b0;
        step();
        chk("midrst pre loadb", 32'(bus.loadb), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst w", 32'(bus.w), 32'd1);
        chk("midrst ctrl", 32'(get_cw()), 32'd0);
        chk("midrst dp_in", 32'(bus.datapath_in), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("postrst c%0d write", k), 32'(bus.write), 32'd0);
            chk($sformatf("postrst c%0d w", k), 32'(bus.w), 32'd1);
        end
        $display("reset abort of ADD mid-GET_B done");

        // Table-driven instructions
        foreach (vecs[i]) begin
            load_ir(vecs[i].instr);
            run_seq(vecs[i].name, vecs[i].ncyc, vecs[i].exp, vecs[i].exp_dp, 1'b0);
        end

        // Illegal instruction: one-cycle bad_instr, no strobes, w stays 1
        load_ir(16'h0000);
        bus.s = 1'b1;
        step();
        bus.s = 1'b0;
        chk("illegal bad c1", 32'(bus.bad_instr), 32'd1);
        chk("illegal w c1", 32'(bus.w), 32'd1);
        chk("illegal ctrl c1", 32'(get_cw()), 32'd0);
        step();
        chk("illegal bad c2", 32'(bus.bad_instr), 32'd0);
        chk("illegal ctrl c2", 32'(get_cw()), 32'd0);
        $display("instr 0000: bad_instr pulse observed=%0d", n_errors == 0);

        // load/s held while busy are ignored
        load_ir(16'hA148);
        run_seq("ADD busy-noise", vecs[3].ncyc, vecs[3].exp, 16'h0048, 1'b1);
        step();
        chk("noise w stays idle", 32'(bus.w), 32'd1);
        chk("noise IR kept", 32'(bus.datapath_in), 32'h0048);

        // Same-edge load + s: old IR executes, new IR used next time
        bus.in   = 16'hD005;
        bus.load = 1'b1;
        run_seq("ADD same-edge load", vecs[3].ncyc, vecs[3].exp, 16'h0048, 1'b0);
        bus.load = 1'b0;
        chk("same-edge new IR", 32'(bus.datapath_in), 32'h0005);
        e = '0; e[0] = mk(1,1,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00);
        run_seq("MOV R0,#5 after reload", 2, e, 16'h0005, 1'b0);

`ifdef SRM_INSTR_CNT_EN
        chk("instr_count", 32'(instr_count), 32'(exp_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
